// File: rtl/adc_sched_pkg.sv
// Shared widths, FSM state encodings and frame-check helper for the ADC sample scheduler.
package adc_sched_pkg;

   localparam int unsigned FRAME_W  = 16;
   localparam int unsigned SAMPLE_W = 12;
   localparam int unsigned HDR_W    = 4;
   localparam int unsigned COUNT_W  = 16;
   localparam int unsigned STATE_W  = 3;

   localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] S_START   = 3'd1;
   localparam logic [STATE_W-1:0] S_CONVERT = 3'd2;
   localparam logic [STATE_W-1:0] S_EVAL    = 3'd3;
   localparam logic [STATE_W-1:0] S_WAIT    = 3'd4;

   // A frame is well formed when its header nibble is all zero.
   function automatic logic frame_ok(input logic [FRAME_W-1:0] frame);
      return frame[FRAME_W-1 -: HDR_W] == '0;
   endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Sample-period timer: clamps and latches the requested period, counts 0..P-1 and flags the last cycle.
module adc_period_timer #(
   parameter int unsigned PERIOD_W       = 18,
   parameter int unsigned DEFAULT_PERIOD = 250000,
   parameter int unsigned MIN_PERIOD     = 40
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic [PERIOD_W-1:0] period_cyc,
   output logic                tick_c
);

   logic [PERIOD_W-1:0] period_eff_c;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] count_q;

   always_comb begin
      period_eff_c = period_cyc;
      if (period_cyc == '0) begin
         period_eff_c = PERIOD_W'(DEFAULT_PERIOD);
      end else if (period_cyc < PERIOD_W'(MIN_PERIOD)) begin
         period_eff_c = PERIOD_W'(MIN_PERIOD);
      end
   end

   assign tick_c = run && (count_q == (period_q - PERIOD_W'(1)));

   // While idle the period tracks the input so the first run uses a fresh value.
   always_ff @(posedge clk) begin
      if (rst) begin
         period_q <= PERIOD_W'(DEFAULT_PERIOD);
         count_q  <= '0;
      end else if (!run || tick_c) begin
         period_q <= period_eff_c;
         count_q  <= '0;
      end else begin
         count_q  <= count_q + PERIOD_W'(1);
      end
   end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Paces ADC conversions at a programmable period, validates frames and hands samples downstream.
module adc_sample_scheduler
   import adc_sched_pkg::*;
#(
   parameter int unsigned DEFAULT_PERIOD = 250000,
   parameter int unsigned PERIOD_W       = 18,
   parameter int unsigned TIMEOUT_CYC    = 32,
   parameter int unsigned MIN_PERIOD     = 40
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period_cyc,
   output logic                conv_start,
   input  logic                conv_done,
   input  logic [FRAME_W-1:0]  conv_data,
   output logic [SAMPLE_W-1:0] sample_data,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic [COUNT_W-1:0]  sample_count,
   output logic                overrun,
   output logic                frame_err,
   output logic                timeout_err,
   input  logic                err_clr
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_nxt;
   logic [FRAME_W-1:0] frame_q;
   logic [TMO_W-1:0]   tmo_q;
   logic               tick_c;
   logic               run_c;
   logic               drain_c;
   logic               load_c;
   logic               set_ovr_c;
   logic               set_frm_c;
   logic               set_tmo_c;

   assign run_c   = (state_q != S_IDLE);
   assign drain_c = sample_valid && sample_ready;

   adc_period_timer #(
      .PERIOD_W      (PERIOD_W),
      .DEFAULT_PERIOD(DEFAULT_PERIOD),
      .MIN_PERIOD    (MIN_PERIOD)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .run       (run_c),
      .period_cyc(period_cyc),
      .tick_c    (tick_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next state plus one-cycle strobes for the output register and sticky flags.
   always_comb begin
      state_nxt = state_q;
      load_c    = 1'b0;
      set_ovr_c = 1'b0;
      set_frm_c = 1'b0;
      set_tmo_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable) state_nxt = S_START;
         end
         S_START: begin
            set_ovr_c = tick_c;
            state_nxt = S_CONVERT;
         end
         S_CONVERT: begin
            set_ovr_c = tick_c;
            if (conv_done) begin
               state_nxt = S_EVAL;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
               set_tmo_c = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_EVAL: begin
            set_ovr_c = tick_c;
            if (!frame_ok(frame_q)) begin
               set_frm_c = 1'b1;
            end else if (!sample_valid || drain_c) begin
               load_c = 1'b1;
            end else begin
               set_ovr_c = 1'b1;
            end
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (!enable) begin
               state_nxt = S_IDLE;
            end else if (tick_c) begin
               state_nxt = S_START;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         conv_start   <= 1'b0;
         frame_q      <= '0;
         tmo_q        <= '0;
         sample_data  <= '0;
         sample_valid <= 1'b0;
         sample_count <= '0;
         overrun      <= 1'b0;
         frame_err    <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         conv_start <= (state_nxt == S_START);

         if ((state_q == S_CONVERT) && conv_done) frame_q <= conv_data;

         if (state_q == S_START) begin
            tmo_q <= '0;
         end else if (state_q == S_CONVERT) begin
            tmo_q <= tmo_q + TMO_W'(1);
         end

         if (load_c) begin
            sample_data  <= frame_q[SAMPLE_W-1:0];
            sample_valid <= 1'b1;
            sample_count <= sample_count + COUNT_W'(1);
         end else if (drain_c) begin
            sample_valid <= 1'b0;
         end

         // A set event in the same cycle as err_clr keeps the flag raised.
         overrun     <= set_ovr_c | (overrun     & ~err_clr);
         frame_err   <= set_frm_c | (frame_err   & ~err_clr);
         timeout_err <= set_tmo_c | (timeout_err & ~err_clr);
      end
   end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Scoreboard bench for adc_sample_scheduler with a behavioural ADC buffer model.
`timescale 1ns/1ps
module tb_adc_sample_scheduler;

   localparam int unsigned PW    = 18;
   localparam int unsigned DEF_P = 1000;

   typedef struct {
      logic [11:0] data;
      logic [15:0] count;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [PW-1:0] period_cyc;
   logic          conv_start;
   logic          conv_done;
   logic [15:0]   conv_data;
   logic [11:0]   sample_data;
   logic          sample_valid;
   logic          sample_ready;
   logic [15:0]   sample_count;
   logic          overrun;
   logic          frame_err;
   logic          timeout_err;
   logic          err_clr;

   exp_t          exp_q[$];
   int unsigned   start_t[$];
   logic [15:0]   frame_q[$];
   int unsigned   cyc = 0;
   int            n_cmp = 0;
   int            n_err = 0;
   int            model_delay = 18;
   bit            model_busy = 1'b0;

   adc_sample_scheduler #(
      .DEFAULT_PERIOD(DEF_P),
      .PERIOD_W      (PW),
      .TIMEOUT_CYC   (32),
      .MIN_PERIOD    (40)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .period_cyc  (period_cyc),
      .conv_start  (conv_start),
      .conv_done   (conv_done),
      .conv_data   (conv_data),
      .sample_data (sample_data),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .sample_count(sample_count),
      .overrun     (overrun),
      .frame_err   (frame_err),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ctrl"}, {27'd0, conv_start, sample_valid, overrun, frame_err, timeout_err}, 32'd0);
      check({tag, "_count"}, 32'(sample_count), 32'd0);
      check({tag, "_data"}, 32'(sample_data), 32'd0);
   endtask

   // Advance to just after the rising edge that starts cycle t.
   task automatic goto(input int unsigned t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance to the falling edge inside cycle t.
   task automatic at_cyc(input int unsigned t);
      do @(negedge clk); while (cyc < t);
   endtask

   function automatic int unsigned st(input int i);
      return (i < start_t.size()) ? start_t[i] : 0;
   endfunction

   task automatic wait_starts(input int n, input int budget);
      int k = 0;
      while ((start_t.size() < n) && (k < budget)) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (start_t.size() < n) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_starts: saw %0d conv_start pulses, expected %0d", start_t.size(), n);
      end
   endtask

   task automatic push_exp(input logic [11:0] d, input logic [15:0] c);
      exp_t e;
      e.data  = d;
      e.count = c;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      check("pending_samples", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      enable       = 1'b0;
      err_clr      = 1'b0;
      sample_ready = 1'b1;
      rst          = 1'b1;
      @(posedge clk);
      #1;
      while (model_busy) begin
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_delay = 18;
      start_t.delete();
      frame_q.delete();
   endtask

   // ADC buffer model: answers each conv_start after model_delay cycles (never if negative).
   initial begin
      conv_done = 1'b0;
      conv_data = 16'h0000;
      forever begin
         @(negedge clk);
         if (conv_start && (model_delay >= 0)) begin
            model_busy = 1'b1;
            repeat (model_delay) @(posedge clk);
            #1;
            conv_data = (frame_q.size() != 0) ? frame_q.pop_front() : 16'h0ABC;
            conv_done = 1'b1;
            @(posedge clk);
            #1;
            conv_done  = 1'b0;
            model_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (conv_start) start_t.push_back(cyc);
   end

   // Output monitor: every accepted sample must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && sample_valid && sample_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_sample: data 0x%0h count %0d, none expected", sample_data, sample_count);
         end else begin
            e = exp_q.pop_front();
            check("sample_data", 32'(sample_data), 32'(e.data));
            check("sample_count", 32'(sample_count), 32'(e.count));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned s;
      rst          = 1'b1;
      enable       = 1'b1;
      period_cyc   = PW'(100);
      sample_ready = 1'b1;
      err_clr      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");

      // Nominal run: period 100, good frames, always ready.
      do_reset();
      period_cyc = PW'(100);
      push_exp(12'hABC, 16'd1);
      push_exp(12'hABC, 16'd2);
      push_exp(12'hABC, 16'd3);
      enable = 1'b1;
      wait_starts(3, 400);
      check("spacing_100_a", 32'(st(1) - st(0)), 32'd100);
      check("spacing_100_b", 32'(st(2) - st(1)), 32'd100);
      s = st(2);
      at_cyc(s + 19);
      check("latency_before", 32'(sample_valid), 32'd0);
      at_cyc(s + 20);
      check("latency_valid", 32'(sample_valid), 32'd1);
      at_cyc(s + 21);
      check("valid_one_cycle", 32'(sample_valid), 32'd0);
      goto(s + 30);
      check("nominal_flags", {29'd0, overrun, frame_err, timeout_err}, 32'd0);

      // Default period (overridden to 1000 here) and the minimum-period clamp.
      do_reset();
      period_cyc = '0;
      push_exp(12'hABC, 16'd1);
      push_exp(12'hABC, 16'd2);
      enable = 1'b1;
      wait_starts(2, 1100);
      check("spacing_default", 32'(st(1) - st(0)), 32'(DEF_P));
      goto(st(1) + 25);
      do_reset();
      period_cyc = PW'(5);
      push_exp(12'hABC, 16'd1);
      push_exp(12'hABC, 16'd2);
      enable = 1'b1;
      wait_starts(2, 100);
      check("spacing_clamp", 32'(st(1) - st(0)), 32'd40);
      goto(st(1) + 25);

      // Malformed frames and err_clr priority.
      do_reset();
      period_cyc = PW'(100);
      frame_q.push_back(16'h8123);
      frame_q.push_back(16'h9FFF);
      enable = 1'b1;
      wait_starts(1, 5);
      s = st(0);
      at_cyc(s + 19);
      check("frame_err_pre", 32'(frame_err), 32'd0);
      at_cyc(s + 20);
      check("frame_err_set", 32'(frame_err), 32'd1);
      check("bad_frame_no_valid", 32'(sample_valid), 32'd0);
      check("bad_frame_count", 32'(sample_count), 32'd0);
      goto(s + 30);
      err_clr = 1'b1;
      goto(s + 31);
      err_clr = 1'b0;
      check("frame_err_clr", 32'(frame_err), 32'd0);
      goto(s + 119);
      err_clr = 1'b1;
      goto(s + 120);
      err_clr = 1'b0;
      check("frame_err_set_wins", 32'(frame_err), 32'd1);
      goto(s + 125);

      // Backpressure: second sample dropped as overrun, first held until accepted.
      do_reset();
      period_cyc   = PW'(100);
      sample_ready = 1'b0;
      frame_q.push_back(16'h0111);
      frame_q.push_back(16'h0222);
      frame_q.push_back(16'h0333);
      push_exp(12'h111, 16'd1);
      push_exp(12'h333, 16'd2);
      enable = 1'b1;
      wait_starts(1, 5);
      s = st(0);
      at_cyc(s + 20);
      check("held_valid", 32'(sample_valid), 32'd1);
      at_cyc(s + 121);
      check("overrun_set", 32'(overrun), 32'd1);
      check("held_data", 32'(sample_data), 32'h111);
      check("held_count", 32'(sample_count), 32'd1);
      goto(s + 130);
      sample_ready = 1'b1;
      goto(s + 131);
      check("drained_valid", 32'(sample_valid), 32'd0);
      goto(s + 230);
      check("third_count", 32'(sample_count), 32'd2);

      // Conversion timeout, then the next tick still starts a conversion.
      do_reset();
      model_delay = -1;
      period_cyc  = PW'(100);
      enable      = 1'b1;
      wait_starts(1, 5);
      s = st(0);
      at_cyc(s + 32);
      check("timeout_pre", 32'(timeout_err), 32'd0);
      at_cyc(s + 33);
      check("timeout_set", 32'(timeout_err), 32'd1);
      wait_starts(2, 120);
      check("spacing_after_timeout", 32'(st(1) - st(0)), 32'd100);
      check("timeout_no_overrun", 32'(overrun), 32'd0);

      // Enable dropped mid-conversion: sample delivered, no further starts.
      do_reset();
      period_cyc = PW'(100);
      push_exp(12'hABC, 16'd1);
      enable = 1'b1;
      wait_starts(1, 5);
      s = st(0);
      goto(s + 5);
      enable = 1'b0;
      goto(s + 250);
      check("disable_starts", 32'(start_t.size()), 32'd1);
      check("disable_count", 32'(sample_count), 32'd1);

      // Reset mid-conversion: outputs clear and the late conv_done is ignored.
      do_reset();
      period_cyc = PW'(100);
      enable = 1'b1;
      wait_starts(1, 5);
      s = st(0);
      goto(s + 5);
      rst    = 1'b1;
      enable = 1'b0;
      goto(s + 6);
      rst = 1'b0;
      check_idle("midconv_reset");
      at_cyc(s + 40);
      check("late_done_valid", 32'(sample_valid), 32'd0);
      check("late_done_count", 32'(sample_count), 32'd0);

      do_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
